// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the multi-port register file: default geometry and the SP/RA reset presets.
// Pure declarations; no latency or flow control.
package regfile_mp_sb_pkg;

    localparam int          RF_DATA_W   = 32;
    localparam int          RF_NUM_REGS = 32;
    localparam int          RF_NUM_RD   = 2;
    localparam int          RF_SP_IDX   = 29;
    localparam int          RF_RA_IDX   = 31;
    localparam logic [31:0] RF_SP_RESET = 32'h8002_03FF;
    localparam logic [31:0] RF_RA_RESET = 32'hDEAD_BEEF;

    // Read select that returns the PC; one past the last register index
    function automatic int rf_sel_pc(input int num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode-side bundle of the register file: read selects/data, issue and both writeback ports.
// Reads are combinational, writes take effect at the next edge; there is no backpressure.
interface regfile_mp_sb_if
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD
) ();
    localparam int AW = $clog2(NUM_REGS);
    localparam int SW = AW + 1;

    logic [DATA_W-1:0]        pc;
    logic [NUM_RD*SW-1:0]     rd_sel;
    logic [NUM_RD*DATA_W-1:0] rd_val;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     iss_ok;
    logic                     wb0_en;
    logic [AW-1:0]            wb0_addr;
    logic [DATA_W-1:0]        wb0_data;
    logic                     wb1_en;
    logic [AW-1:0]            wb1_addr;
    logic [DATA_W-1:0]        wb1_data;

    modport master (
        output pc, rd_sel, iss_en, iss_addr,
        output wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
        input  rd_val, rd_busy, iss_ok
    );

    modport slave (
        input  pc, rd_sel, iss_en, iss_addr,
        input  wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
        output rd_val, rd_busy, iss_ok
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register, set by issue, cleared by writeback.
// Queries are combinational and see same-cycle writebacks; state updates one cycle later; no backpressure.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 wb0_en,
    input  logic [AW-1:0]        wb0_addr,
    input  logic                 wb1_en,
    input  logic [AW-1:0]        wb1_addr,
    input  logic [NUM_RD*AW-1:0] q_addr,
    output logic [NUM_RD-1:0]    q_busy,
    output logic                 iss_ok
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] hit;
    logic [NUM_REGS-1:0] set;
    logic [AW-1:0]       qa;

    // Set is applied after clear so a new producer wins over a retiring one
    always_comb begin
        hit = '0;
        set = '0;
        if (wb0_en) hit[wb0_addr] = 1'b1;
        if (wb1_en) hit[wb1_addr] = 1'b1;
        if (iss_en) set[iss_addr] = 1'b1;
        busy_d    = (busy_q & ~hit) | set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        q_busy = '0;
        qa     = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            qa        = q_addr[i*AW +: AW];
            q_busy[i] = busy_q[qa] & ~hit[qa];
        end
    end

    assign iss_ok = ~busy_q[iss_addr] | hit[iss_addr] | (iss_addr == '0);

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with writeback forwarding, PC/zero pseudo-registers and a busy scoreboard.
// Reads 0 cycles (combinational), writes land 1 cycle later; no backpressure, decode gates issue via iss_ok.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int                DATA_W   = RF_DATA_W,
    parameter int                NUM_REGS = RF_NUM_REGS,
    parameter int                NUM_RD   = RF_NUM_RD,
    parameter int                SP_IDX   = RF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(RF_SP_RESET),
    parameter int                RA_IDX   = RF_RA_IDX,
    parameter logic [DATA_W-1:0] RA_RESET = DATA_W'(RF_RA_RESET)
) (
    input  logic            clk,
    input  logic            rst,
    regfile_mp_sb_if.slave  bus
);

    localparam int            AW     = $clog2(NUM_REGS);
    localparam int            SW     = AW + 1;
    localparam logic [SW-1:0] SEL_PC = SW'(rf_sel_pc(NUM_REGS));

    logic [DATA_W-1:0]   regs_q   [NUM_REGS];
    logic [DATA_W-1:0]   regs_d   [NUM_REGS];
    logic [DATA_W-1:0]   rst_vals [NUM_REGS];
    logic [DATA_W-1:0]   val_w    [NUM_RD];
    logic                busy_w   [NUM_RD];
    logic [NUM_RD*AW-1:0] q_addr;
    logic [NUM_RD-1:0]   q_busy;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_rst
        assign rst_vals[k] = (k == SP_IDX) ? SP_RESET :
                             (k == RA_IDX) ? RA_RESET : '0;
    end

    // wb1 is applied last so it wins a same-address collision
    always_comb begin
        regs_d = regs_q;
        if (bus.wb0_en && bus.wb0_addr != '0) regs_d[bus.wb0_addr] = bus.wb0_data;
        if (bus.wb1_en && bus.wb1_addr != '0) regs_d[bus.wb1_addr] = bus.wb1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) regs_q <= rst_vals;
        else     regs_q <= regs_d;
    end

    always_comb begin
        q_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            q_addr[i*AW +: AW] = bus.rd_sel[i*SW +: AW];
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .AW       (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wb0_en   (bus.wb0_en),
        .wb0_addr (bus.wb0_addr),
        .wb1_en   (bus.wb1_en),
        .wb1_addr (bus.wb1_addr),
        .q_addr   (q_addr),
        .q_busy   (q_busy),
        .iss_ok   (bus.iss_ok)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [SW-1:0] sel;
        logic [AW-1:0] idx;
        logic          in_rng;

        assign sel    = bus.rd_sel[i*SW +: SW];
        assign idx    = sel[AW-1:0];
        // Real registers only: excludes r0, the PC select and anything beyond it
        assign in_rng = ~sel[SW-1] && (idx != '0);

        assign val_w[i] = (sel == SEL_PC)                       ? bus.pc       :
                          !in_rng                               ? '0           :
                          (bus.wb1_en && bus.wb1_addr == idx)   ? bus.wb1_data :
                          (bus.wb0_en && bus.wb0_addr == idx)   ? bus.wb0_data :
                                                                  regs_q[idx];
        assign busy_w[i] = in_rng & q_busy[i];
    end

    always_comb begin
        bus.rd_val  = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_val[i*DATA_W +: DATA_W] = val_w[i];
            bus.rd_busy[i]                 = busy_w[i];
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed plus randomized bench for regfile_mp_sb against an array-based reference model.
module tb_regfile_mp_sb;
    import regfile_mp_sb_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;
    localparam int SW  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

    regfile_mp_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_reg  [NR];
    bit          m_busy [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_hit(input int a);
        return (bus.wb0_en && int'(bus.wb0_addr) == a) || (bus.wb1_en && int'(bus.wb1_addr) == a);
    endfunction

    function automatic logic [31:0] exp_val(input int s);
        if (s == NR) return bus.pc;
        if (s == 0 || s > NR) return 32'h0;
        if (bus.wb1_en && int'(bus.wb1_addr) == s) return bus.wb1_data;
        if (bus.wb0_en && int'(bus.wb0_addr) == s) return bus.wb0_data;
        return m_reg[s];
    endfunction

    function automatic logic [31:0] exp_busy(input int s);
        if (s == 0 || s >= NR) return 32'h0;
        return (m_busy[s] && !wb_hit(s)) ? 32'h1 : 32'h0;
    endfunction

    function automatic logic [31:0] exp_iss_ok();
        int a;
        a = int'(bus.iss_addr);
        return (!m_busy[a] || wb_hit(a) || a == 0) ? 32'h1 : 32'h0;
    endfunction

    task automatic check_all(input string ctx);
        int s;
        for (int p = 0; p < NRD; p++) begin
            s = int'(bus.rd_sel[p*SW +: SW]);
            chk($sformatf("%s.val%0d", ctx, p), bus.rd_val[p*DW +: DW], exp_val(s));
            chk($sformatf("%s.busy%0d", ctx, p), 32'(bus.rd_busy[p]), exp_busy(s));
        end
        chk($sformatf("%s.iss_ok", ctx), 32'(bus.iss_ok), exp_iss_ok());
    endtask

    task automatic model_update();
        if (rst) begin
            for (int k = 0; k < NR; k++) begin
                m_reg[k]  = 32'h0;
                m_busy[k] = 1'b0;
            end
            m_reg[29] = 32'h8002_03FF;
            m_reg[31] = 32'hDEAD_BEEF;
        end else begin
            if (bus.wb0_en && bus.wb0_addr != 0) m_reg[bus.wb0_addr] = bus.wb0_data;
            if (bus.wb1_en && bus.wb1_addr != 0) m_reg[bus.wb1_addr] = bus.wb1_data;
            if (bus.wb0_en) m_busy[bus.wb0_addr] = 1'b0;
            if (bus.wb1_en) m_busy[bus.wb1_addr] = 1'b0;
            if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.iss_en   = 1'b0;
        bus.wb0_en   = 1'b0;
        bus.wb1_en   = 1'b0;
    endtask

    task automatic set_sel(input int a, input int b);
        bus.rd_sel = {SW'(b), SW'(a)};
    endtask

    task automatic do_wb0(input int a, input logic [31:0] d);
        bus.wb0_en = 1'b1; bus.wb0_addr = AW'(a); bus.wb0_data = d;
    endtask

    task automatic do_wb1(input int a, input logic [31:0] d);
        bus.wb1_en = 1'b1; bus.wb1_addr = AW'(a); bus.wb1_data = d;
    endtask

    task automatic do_iss(input int a);
        bus.iss_en = 1'b1; bus.iss_addr = AW'(a);
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : int'($urandom_range(0, 7));
    endfunction

    function automatic int rnd_sel();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(NR, 63)) : rnd_addr();
    endfunction

    initial begin
        for (int k = 0; k < NR; k++) begin
            m_reg[k]  = 32'h0;
            m_busy[k] = 1'b0;
        end
        rst = 1'b1;
        idle();
        bus.iss_addr = '0; bus.wb0_addr = '0; bus.wb1_addr = '0;
        bus.wb0_data = '0; bus.wb1_data = '0; bus.pc = '0;
        set_sel(0, 0);
        tick();
        tick();
        rst = 1'b0;

        // reset presets
        set_sel(29, 31); #1;
        chk("rst_sp", bus.rd_val[31:0], 32'h8002_03FF);
        chk("rst_ra", bus.rd_val[63:32], 32'hDEAD_BEEF);
        chk("rst_busy", 32'(bus.rd_busy), 32'h0);
        check_all("rst");
        set_sel(5, 9); bus.iss_addr = 9; #1;
        chk("rst_r5", bus.rd_val[31:0], 32'h0);
        chk("rst_iss_ok", 32'(bus.iss_ok), 32'h1);

        // same-cycle forwarding from wb1
        do_wb1(5, 32'h1234_5678); set_sel(5, 5); #1;
        chk("fwd_same", bus.rd_val[31:0], 32'h1234_5678);
        check_all("fwd");
        tick(); idle(); #1;
        chk("fwd_stored", bus.rd_val[63:32], 32'h1234_5678);

        // wb1 beats wb0 on the same address
        do_wb0(7, 32'hAAAA); do_wb1(7, 32'hBBBB); set_sel(7, 5); #1;
        chk("prio_fwd", bus.rd_val[31:0], 32'hBBBB);
        tick(); idle(); #1;
        chk("prio_stored", bus.rd_val[31:0], 32'hBBBB);

        // scoreboard set, hold, clear
        do_iss(9); tick(); idle(); tick(); tick();
        set_sel(9, 9); bus.iss_addr = 9; #1;
        chk("sb_busy", 32'(bus.rd_busy), 32'h3);
        chk("sb_iss_ok", 32'(bus.iss_ok), 32'h0);
        do_wb0(9, 32'h0909_0909); #1;
        chk("sb_clr_busy", 32'(bus.rd_busy), 32'h0);
        chk("sb_clr_iss_ok", 32'(bus.iss_ok), 32'h1);
        chk("sb_clr_val", bus.rd_val[31:0], 32'h0909_0909);
        tick(); idle(); #1;
        chk("sb_after", 32'(bus.rd_busy), 32'h0);

        // set beats clear
        do_iss(9); do_wb1(9, 32'h9999_0000); #1;
        tick(); idle(); #1;
        chk("sbc_val", bus.rd_val[31:0], 32'h9999_0000);
        chk("sbc_busy", 32'(bus.rd_busy), 32'h3);
        chk("sbc_iss_ok", 32'(bus.iss_ok), 32'h0);
        do_wb0(9, 32'h1); tick(); idle();

        // r0 and PC pseudo-registers
        do_wb1(0, 32'hFFFF); set_sel(0, 32); bus.pc = 32'h0040_0010; #1;
        chk("r0_same", bus.rd_val[31:0], 32'h0);
        chk("pc_val", bus.rd_val[63:32], 32'h0040_0010);
        tick(); idle(); #1;
        chk("r0_after", bus.rd_val[31:0], 32'h0);
        set_sel(40, 63); #1;
        chk("oob_val", bus.rd_val, 64'h0);
        chk("oob_busy", 32'(bus.rd_busy), 32'h0);

        // reset mid-operation
        do_wb1(29, 32'h1); do_iss(9); do_wb0(3, 32'h3333); tick(); idle();
        do_iss(9); do_wb0(3, 32'h4444); rst = 1'b1; tick(); rst = 1'b0; idle();
        set_sel(3, 29); #1;
        chk("mid_r3", bus.rd_val[31:0], 32'h0);
        chk("mid_sp", bus.rd_val[63:32], 32'h8002_03FF);
        set_sel(9, 31); bus.iss_addr = 9; #1;
        chk("mid_busy9", 32'(bus.rd_busy), 32'h0);
        chk("mid_ra", bus.rd_val[63:32], 32'hDEAD_BEEF);
        chk("mid_iss_ok", 32'(bus.iss_ok), 32'h1);
        check_all("mid");

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.iss_en   = ($urandom_range(0, 2) == 0);
            bus.iss_addr = AW'(rnd_addr());
            bus.wb0_en   = ($urandom_range(0, 1) == 0);
            bus.wb0_addr = AW'(rnd_addr());
            bus.wb0_data = $urandom();
            bus.wb1_en   = ($urandom_range(0, 1) == 0);
            bus.wb1_addr = AW'(rnd_addr());
            bus.wb1_data = $urandom();
            bus.pc       = $urandom();
            set_sel(rnd_sel(), rnd_sel());
            rst = ($urandom_range(0, 63) == 0);
            #1;
            check_all("rnd");
            tick();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
